// File: rtl/pic_pkg.sv
// pic_pkg: shared trigger-mode encodings, default channel count and request vector type
package pic_pkg;
    localparam logic TRIG_EDGE   = 1'b0;
    localparam logic TRIG_LEVEL  = 1'b1;
    localparam int   PIC_NUM_IRQ = 8;
    typedef logic [PIC_NUM_IRQ-1:0] IRQ_VEC;
endpackage

// File: rtl/irq_request_reg_if.sv
// irq_request_reg_if: request-register bus (master = pin/INTA side driving, slave = request register)
//   levelMode/irqIn/freeze/clearReq/clearLost : master -> slave
//   irr/lostIrq/anyPending                    : slave -> master
interface irq_request_reg_if import pic_pkg::*; #(parameter int NUM_IRQ = PIC_NUM_IRQ);
    logic [NUM_IRQ-1:0] levelMode;
    logic [NUM_IRQ-1:0] irqIn;
    logic               freeze;
    logic [NUM_IRQ-1:0] clearReq;
    logic [NUM_IRQ-1:0] clearLost;
    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] lostIrq;
    logic               anyPending;
    modport master (output levelMode, irqIn, freeze, clearReq, clearLost,
                    input  irr, lostIrq, anyPending);
    modport slave  (input  levelMode, irqIn, freeze, clearReq, clearLost,
                    output irr, lostIrq, anyPending);
endinterface

// File: rtl/irq_sync_chain.sv
// irq_sync_chain: WIDTH-wide, STAGES-deep flop chain for asynchronous request pins
//   clk, reset : clock and synchronous active-high reset (chain clears to 0)
//   d_i        : raw asynchronous input vector
//   q_o        : synchronised output, STAGES edges later
module irq_sync_chain #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    always_ff @(posedge clk) begin
        if (reset) chain_q <= '0;
        else       chain_q <= {chain_q[STAGES-2:0], d_i};
    end
    assign q_o = chain_q[STAGES-1];
endmodule

// File: rtl/irq_request_reg.sv
// irq_request_reg: PIC interrupt request register with per-channel edge/level capture and lost-edge flags
//   clk, reset : clock and synchronous active-high reset
//   bus.slave  : levelMode/irqIn/freeze/clearReq/clearLost in; irr/lostIrq/anyPending out
//   IRQ_SYNC_EN: when defined, irqIn first passes an irq_sync_chain of SYNC_STAGES flops
module irq_request_reg import pic_pkg::*; #(
    parameter int NUM_IRQ     = PIC_NUM_IRQ,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    irq_request_reg_if.slave   bus
);
    logic [NUM_IRQ-1:0] raw, lvl, edg, set_v;
    logic [NUM_IRQ-1:0] smp_q, prev_q, irr_q, lost_q;
    logic [NUM_IRQ-1:0] prev_d, irr_d, lost_d;
    logic               any_q;
`ifdef IRQ_SYNC_EN
    irq_sync_chain #(.WIDTH(NUM_IRQ), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.irqIn),
        .q_o   (raw)
    );
`else
    assign raw = bus.irqIn;
`endif
    always_comb begin
        lvl    = ~(bus.levelMode ^ {NUM_IRQ{TRIG_LEVEL}});
        edg    = smp_q & ~prev_q;
        set_v  = (lvl & smp_q) | (~lvl & edg);
        // prev is held while frozen so an edge arriving during INTA is seen once freeze drops
        prev_d = bus.freeze ? prev_q : smp_q;
        // level bits follow the line when unfrozen; a set always beats a coincident clear
        irr_d  = bus.freeze ? (irr_q & ~bus.clearReq)
                            : set_v | (~lvl & irr_q & ~bus.clearReq);
        lost_d = (~{NUM_IRQ{bus.freeze}} & ~lvl & edg & irr_q & ~bus.clearReq)
               | (lost_q & ~bus.clearLost);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            smp_q  <= '0;
            prev_q <= '0;
            irr_q  <= '0;
            lost_q <= '0;
            any_q  <= 1'b0;
        end else begin
            smp_q  <= raw;
            prev_q <= prev_d;
            irr_q  <= irr_d;
            lost_q <= lost_d;
            any_q  <= |irr_d;
        end
    end
    assign bus.irr        = irr_q;
    assign bus.lostIrq    = lost_q;
    assign bus.anyPending = any_q;
endmodule

// File: tb/tb_irq_request_reg.sv
// tb_irq_request_reg: directed plus random checks of irq_request_reg against a per-channel reference model
module tb_irq_request_reg;
    import pic_pkg::*;
    localparam int N = 8;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    IRQ_VEC m_smp, m_prev, m_irr, m_lost;
    logic   m_any;
    irq_request_reg_if #(.NUM_IRQ(N)) ifc ();
    irq_request_reg #(.NUM_IRQ(N), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Channel-by-channel restatement of the request rules, applied at each rising edge.
    task automatic model_step();
        IRQ_VEC nirr, nlost;
        bit e;
        if (reset) begin
            m_smp = '0; m_prev = '0; m_irr = '0; m_lost = '0; m_any = 1'b0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            e = m_smp[i] && !m_prev[i];
            nlost[i] = m_lost[i] && !ifc.clearLost[i];
            if (ifc.freeze)
                nirr[i] = m_irr[i] && !ifc.clearReq[i];
            else if (ifc.levelMode[i] == TRIG_LEVEL)
                nirr[i] = m_smp[i];
            else begin
                nirr[i] = e || (m_irr[i] && !ifc.clearReq[i]);
                if (e && m_irr[i] && !ifc.clearReq[i]) nlost[i] = 1'b1;
            end
        end
        if (!ifc.freeze) m_prev = m_smp;
        m_smp  = ifc.irqIn;
        m_irr  = nirr;
        m_lost = nlost;
        m_any  = (nirr != 0);
    endtask
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("irr_model", ifc.irr, m_irr);
        chk("lost_model", ifc.lostIrq, m_lost);
        chk("any_model", ifc.anyPending, m_any);
    endtask
    initial begin
        reset = 1'b1;
        ifc.levelMode = '0; ifc.irqIn = 8'hFF; ifc.freeze = 1'b0;
        ifc.clearReq = '0; ifc.clearLost = '0;
        tick(); tick();
        chk("rst_irr", ifc.irr, 8'h00);
        chk("rst_any", ifc.anyPending, 1'b0);
        reset = 1'b0;
        tick();
        chk("rel_r1_irr", ifc.irr, 8'h00);
        tick();
        chk("rel_r2_irr", ifc.irr, 8'hFF);
        chk("rel_r2_any", ifc.anyPending, 1'b1);
        ifc.irqIn = '0; ifc.clearReq = 8'hFF;
        tick();
        chk("clr_all", ifc.irr, 8'h00);
        ifc.clearReq = '0;
        tick();
        ifc.irqIn = 8'h08; tick();
        ifc.irqIn = 8'h00; tick();
        chk("pulse3", ifc.irr, 8'h08);
        tick();
        chk("pulse3_hold", ifc.irr, 8'h08);
        ifc.clearReq = 8'h08; tick();
        chk("pulse3_clr", ifc.irr, 8'h00);
        ifc.clearReq = '0; tick();
        ifc.levelMode = 8'h01; ifc.irqIn = 8'h01;
        tick();
        chk("lvl_t1", ifc.irr, 8'h00);
        tick();
        chk("lvl_t2", ifc.irr, 8'h01);
        tick();
        chk("lvl_t3", ifc.irr, 8'h01);
        ifc.irqIn = 8'h00;
        tick();
        chk("lvl_t4", ifc.irr, 8'h01);
        tick();
        chk("lvl_drop", ifc.irr, 8'h00);
        chk("lvl_nolost", ifc.lostIrq, 8'h00);
        ifc.levelMode = '0; tick();
        ifc.irqIn = 8'h20; tick();
        ifc.irqIn = 8'h00; tick();
        tick();
        ifc.irqIn = 8'h20; tick();
        ifc.irqIn = 8'h00; tick();
        chk("lost5", ifc.lostIrq, 8'h20);
        ifc.clearLost = 8'h20; tick();
        chk("lost5_clr", ifc.lostIrq, 8'h00);
        chk("lost5_irr", ifc.irr, 8'h20);
        ifc.clearLost = '0; ifc.clearReq = 8'h20; tick();
        ifc.clearReq = '0;
        ifc.irqIn = 8'h10; tick();
        ifc.irqIn = 8'h00; tick();
        chk("irr4_set", ifc.irr, 8'h10);
        ifc.freeze = 1'b1; ifc.irqIn = 8'h04; ifc.clearReq = 8'h10;
        tick();
        chk("frz_clr4", ifc.irr, 8'h00);
        ifc.clearReq = '0; tick();
        chk("frz_no2", ifc.irr, 8'h00);
        ifc.freeze = 1'b0; tick();
        chk("unfrz_2", ifc.irr, 8'h04);
        ifc.irqIn = 8'h00; ifc.clearReq = 8'h04; tick();
        ifc.clearReq = '0;
        ifc.irqIn = 8'h02; tick();
        ifc.irqIn = 8'h00; tick();
        tick();
        ifc.irqIn = 8'h02; tick();
        ifc.irqIn = 8'h00; ifc.clearReq = 8'h02; tick();
        chk("race_irr1", ifc.irr, 8'h02);
        chk("race_lost1", ifc.lostIrq, 8'h00);
        ifc.clearReq = '0; tick();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(99) == 0);
            ifc.irqIn = 8'($urandom);
            if ($urandom_range(15) == 0) ifc.levelMode = 8'($urandom);
            ifc.freeze = ($urandom_range(4) == 0);
            ifc.clearReq = ($urandom_range(2) == 0) ? 8'($urandom) : 8'h00;
            ifc.clearLost = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
